// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the direct-mapped data cache.
// Holds the miss-handling FSM states, the load funct3 and store size codes,
// the block/word geometry and the access-alignment helper.
package dcache_pkg;

   localparam int WORD_W      = 32;
   localparam int BLOCK_W     = 128;
   localparam int BLOCK_BYTES = BLOCK_W / 8;
   localparam int OFFSET_W    = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2,
      FILL      = 2'd3
   } state_e;

   // Load codes as carried on READ_EN[2:0].
   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } load_f3_e;

   // Store sizes as carried on WRITE_EN[1:0]; loads share this encoding in funct3[1:0].
   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } store_size_e;

   // The alignment unit either extracts load data or produces a byte-lane mask.
   typedef enum logic {
      ALIGN_LOAD = 1'b0,
      ALIGN_MASK = 1'b1
   } align_mode_e;

   // Halfword accesses drop ADDR[0], word accesses drop ADDR[1:0]; nothing traps.
   function automatic logic [OFFSET_W-1:0] align_offset(input logic [OFFSET_W-1:0] offset,
                                                        input logic [1:0]          size);
      case (size)
         SZ_H:    align_offset = {offset[3:1], 1'b0};
         SZ_W:    align_offset = {offset[3:2], 2'b00};
         default: align_offset = offset;
      endcase
   endfunction

endpackage

// File: rtl/dcache_direct_mapped_if.sv
// dcache_direct_mapped_if: block-wide bus between the data cache and main memory.
// The cache is the master (issues block reads/writes); memory is the slave and
// signals completion by dropping MEM_BUSYWAIT while a request is asserted.
interface dcache_direct_mapped_if #(
   parameter int MEM_ADDR_W = 28
) ();
   import dcache_pkg::*;

   logic                  MEM_READ;
   logic                  MEM_WRITE;
   logic [MEM_ADDR_W-1:0] MEM_ADDRESS;
   logic [BLOCK_W-1:0]    MEM_WRITEDATA;
   logic [BLOCK_W-1:0]    MEM_READDATA;
   logic                  MEM_BUSYWAIT;

   modport master (
      output MEM_READ,
      output MEM_WRITE,
      output MEM_ADDRESS,
      output MEM_WRITEDATA,
      input  MEM_READDATA,
      input  MEM_BUSYWAIT
   );

   modport slave (
      input  MEM_READ,
      input  MEM_WRITE,
      input  MEM_ADDRESS,
      input  MEM_WRITEDATA,
      output MEM_READDATA,
      output MEM_BUSYWAIT
   );

endinterface

// File: rtl/dcache_load_align.sv
// dcache_load_align: combinational byte-lane unit.
// ALIGN_LOAD: picks the addressed byte/half/word out of a 128-bit block and
//             sign- or zero-extends it according to funct3.
// ALIGN_MASK: ignores the block and returns the 16-bit byte-lane write mask
//             for an access of size funct3[1:0] at the offset (upper bits 0).
module dcache_load_align
   import dcache_pkg::*;
(
   input  align_mode_e         mode,
   input  logic [BLOCK_W-1:0]  block,
   input  logic [OFFSET_W-1:0] offset,
   input  logic [2:0]          funct3,
   output logic [WORD_W-1:0]   result
);

   logic [OFFSET_W-1:0]    off_al;
   logic [WORD_W-1:0]      word_sel;
   logic [7:0]             byte_sel;
   logic [15:0]            half_sel;
   logic [WORD_W-1:0]      load_val;
   logic [BLOCK_BYTES-1:0] lane_mask;

   // Select and extend the addressed field, and build the lane mask.
   // NOTE: every variable gets a default at the top of a combinational block so
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      off_al    = align_offset(offset, funct3[1:0]);
      word_sel  = block[{off_al[3:2], 5'b0} +: WORD_W];
      byte_sel  = word_sel[{off_al[1:0], 3'b0} +: 8];
      half_sel  = word_sel[{off_al[1], 4'b0} +: 16];
      load_val  = '0;
      lane_mask = '0;

      case (funct3)
         F3_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   load_val = {{16{half_sel[15]}}, half_sel};
         F3_LW:   load_val = word_sel;
         F3_LBU:  load_val = {24'b0, byte_sel};
         F3_LHU:  load_val = {16'b0, half_sel};
         default: load_val = '0;
      endcase

      case (funct3[1:0])
         SZ_B:    lane_mask = 16'h0001 << off_al;
         SZ_H:    lane_mask = 16'h0003 << off_al;
         SZ_W:    lane_mask = 16'h000F << off_al;
         default: lane_mask = '0;
      endcase

      result = (mode == ALIGN_MASK) ? {16'b0, lane_mask} : load_val;
   end

endmodule

// File: rtl/dcache_direct_mapped.sv
// dcache_direct_mapped: direct-mapped, write-back, write-allocate data cache
// with 16-byte blocks for the core's stage-4 memory port.
// Hits complete combinationally in the same cycle; misses stall the core via
// BUSY_WAIT while the FSM writes back a dirty victim, fetches the block and
// fills it, after which the held request hits.
// Optional build macro DCACHE_STATS_EN adds HIT_COUNT / MISS_COUNT outputs.
module dcache_direct_mapped
   import dcache_pkg::*;
#(
   parameter int INDEX_BITS = 3,
   parameter int MEM_ADDR_W = 28
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [3:0]             READ_EN,
   input  logic [2:0]             WRITE_EN,
   input  logic [WORD_W-1:0]      ADDR,
   input  logic [WORD_W-1:0]      WRITE_DATA,
   output logic [WORD_W-1:0]      READ_DATA,
   output logic                   BUSY_WAIT,
`ifdef DCACHE_STATS_EN
   output logic [31:0]            HIT_COUNT,
   output logic [31:0]            MISS_COUNT,
`endif
   dcache_direct_mapped_if.master mem
);

   localparam int TAG_W = MEM_ADDR_W - INDEX_BITS;
   localparam int SETS  = 1 << INDEX_BITS;

   // Request decode and address split.
   logic                  load_req;
   logic                  store_req;
   logic                  req;
   logic [OFFSET_W-1:0]   offset;
   logic [INDEX_BITS-1:0] index;
   logic [TAG_W-1:0]      tag;
   logic                  hit;

   // Storage: data and tag arrays, per-set valid/dirty bits.
   logic [BLOCK_W-1:0] data_q [SETS];
   logic [BLOCK_W-1:0] data_d [SETS];
   logic [TAG_W-1:0]   tag_q  [SETS];
   logic [TAG_W-1:0]   tag_d  [SETS];
   logic [SETS-1:0]    valid_q, valid_d;
   logic [SETS-1:0]    dirty_q, dirty_d;

   // Miss handling: FSM, fetched-block buffer and registered memory outputs.
   state_e                state_q, state_d;
   logic [BLOCK_W-1:0]    fill_q, fill_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [BLOCK_W-1:0]    mem_wdata_q, mem_wdata_d;

   // Store datapath.
   logic [WORD_W-1:0]      load_word;
   logic [WORD_W-1:0]      mask_word;
   logic [BLOCK_BYTES-1:0] byte_mask;
   logic [BLOCK_W-1:0]     store_rep;
   logic [BLOCK_W-1:0]     merged_block;
   logic                   unused_mask_hi;

   // A store wins over a simultaneous load; the load is then ignored.
   assign store_req = WRITE_EN[2];
   assign load_req  = READ_EN[3] & ~store_req;
   assign req       = READ_EN[3] | WRITE_EN[2];
   assign offset    = ADDR[OFFSET_W-1:0];
   assign index     = ADDR[OFFSET_W +: INDEX_BITS];
   assign tag       = ADDR[WORD_W-1 -: TAG_W];
   assign hit       = valid_q[index] & (tag_q[index] == tag);

   dcache_load_align u_load_align (
      .mode   (ALIGN_LOAD),
      .block  (data_q[index]),
      .offset (offset),
      .funct3 (READ_EN[2:0]),
      .result (load_word)
   );

   dcache_load_align u_store_mask (
      .mode   (ALIGN_MASK),
      .block  ({BLOCK_W{1'b0}}),
      .offset (offset),
      .funct3 ({1'b0, WRITE_EN[1:0]}),
      .result (mask_word)
   );

   assign byte_mask      = mask_word[BLOCK_BYTES-1:0];
   assign unused_mask_hi = ^mask_word[WORD_W-1:BLOCK_BYTES];

   // Stall while a request misses or any miss step is still in progress.
   assign BUSY_WAIT = ~RESET & req & (~hit | (state_q != IDLE));

   // Load data only on a completed hit; otherwise held at zero.
   assign READ_DATA = (~RESET & load_req & hit & (state_q == IDLE)) ? load_word : '0;

   // Replicate store data across the block and merge it into the enabled lanes.
   always_comb begin
      case (WRITE_EN[1:0])
         SZ_B:    store_rep = {16{WRITE_DATA[7:0]}};
         SZ_H:    store_rep = {8{WRITE_DATA[15:0]}};
         default: store_rep = {4{WRITE_DATA}};
      endcase
      merged_block = data_q[index];
      for (int b = 0; b < BLOCK_BYTES; b++) begin
         if (byte_mask[b]) merged_block[b*8 +: 8] = store_rep[b*8 +: 8];
      end
   end

   // Next-state logic: hit updates, miss sequencing and memory request outputs.
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      tag_d       = tag_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      fill_d      = fill_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  if (store_req) begin
                     data_d[index]  = merged_block;
                     dirty_d[index] = 1'b1;
                  end
               end else if (valid_q[index] & dirty_q[index]) begin
                  state_d = WRITEBACK;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         WRITEBACK: begin
            if (!mem.MEM_BUSYWAIT) state_d = FETCH;
         end
         FETCH: begin
            if (!mem.MEM_BUSYWAIT) begin
               fill_d  = mem.MEM_READDATA;
               state_d = FILL;
            end
         end
         FILL: begin
            data_d[index]  = fill_q;
            tag_d[index]   = tag;
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Address and victim data are captured on entry so they hold for the transfer.
      mem_read_d  = (state_d == FETCH);
      mem_write_d = (state_d == WRITEBACK);
      if ((state_q == IDLE) && (state_d == WRITEBACK)) begin
         mem_addr_d  = {tag_q[index], index};
         mem_wdata_d = data_q[index];
      end else if ((state_q != FETCH) && (state_d == FETCH)) begin
         mem_addr_d = ADDR[WORD_W-1:OFFSET_W];
      end
   end

   // Control state: FSM, valid/dirty bits and memory request registers.
   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Data, tag and fill-buffer storage; updates are suppressed during reset.
   // NOTE: these arrays are deliberately not reset -- the cleared valid bits make
   // their contents unobservable, and leaving them out keeps them plain RAM.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         data_q <= data_d;
         tag_q  <= tag_d;
         fill_q <= fill_d;
      end
   end

   assign mem.MEM_READ      = mem_read_q;
   assign mem.MEM_WRITE     = mem_write_q;
   assign mem.MEM_ADDRESS   = mem_addr_q;
   assign mem.MEM_WRITEDATA = mem_wdata_q;

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;
   logic        after_fill_q, after_fill_d;

   // Count first-cycle hits (not the replay after a fill) and miss entries.
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      after_fill_d = (state_q == FILL);
      if ((state_q == IDLE) && req && hit && !after_fill_q) hit_count_d = hit_count_q + 32'd1;
      if ((state_q == IDLE) && (state_d != IDLE)) miss_count_d = miss_count_q + 32'd1;
   end

   // Statistics registers, wrapping naturally at 2^32.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
         after_fill_q <= 1'b0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         after_fill_q <= after_fill_d;
      end
   end

   assign HIT_COUNT  = hit_count_q;
   assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// tb_dcache_direct_mapped: directed bench for the direct-mapped data cache.
// A block memory model with fixed latency answers on the negative edge; inputs
// are driven and outputs sampled shortly after each rising edge.
module tb_dcache_direct_mapped;

   localparam logic [127:0] BLK_A   = 128'h11112222_DDDDCCCC_BBBBAAAA_87654321;
   localparam logic [127:0] BLK_A_M = 128'h11112222_DDDDCCCC_BBBBAAAA_BEEF4321;
   localparam logic [127:0] BLK_B   = 128'h44443333_CAFEF00D_01234567_A5A5A5A5;
   localparam int           MEM_LAT = 5;
   localparam int           BOUND   = 40;

   localparam logic [3:0] LB  = 4'b1000;
   localparam logic [3:0] LH  = 4'b1001;
   localparam logic [3:0] LW  = 4'b1010;
   localparam logic [3:0] LBU = 4'b1100;
   localparam logic [3:0] LHU = 4'b1101;
   localparam logic [2:0] SB  = 3'b100;
   localparam logic [2:0] SH  = 3'b101;
   localparam logic [2:0] SW  = 3'b110;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [3:0]  READ_EN;
   logic [2:0]  WRITE_EN;
   logic [31:0] ADDR;
   logic [31:0] WRITE_DATA;
   logic [31:0] READ_DATA;
   logic        BUSY_WAIT;
`ifdef DCACHE_STATS_EN
   logic [31:0] HIT_COUNT;
   logic [31:0] MISS_COUNT;
`endif

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc;

   dcache_direct_mapped_if #(.MEM_ADDR_W(28)) mem_bus ();

   dcache_direct_mapped dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .READ_EN    (READ_EN),
      .WRITE_EN   (WRITE_EN),
      .ADDR       (ADDR),
      .WRITE_DATA (WRITE_DATA),
      .READ_DATA  (READ_DATA),
      .BUSY_WAIT  (BUSY_WAIT),
`ifdef DCACHE_STATS_EN
      .HIT_COUNT  (HIT_COUNT),
      .MISS_COUNT (MISS_COUNT),
`endif
      .mem        (mem_bus)
   );

   always #5 CLK = ~CLK;

   // Memory model: initial contents per block, overridden by write-backs.
   logic [127:0] mem_store [logic [27:0]];
   logic [27:0]  wb_addr_seen;
   logic [127:0] wb_data_seen;
   int           mem_cnt = 0;

   function automatic logic [127:0] base_block(input logic [27:0] a);
      case (a)
         28'h0000004: base_block = BLK_A;
         28'h0000014: base_block = BLK_B;
         default:     base_block = {4{4'h0, a}};
      endcase
   endfunction

   always @(negedge CLK) begin
      if (mem_bus.MEM_READ || mem_bus.MEM_WRITE) begin
         if (mem_cnt == MEM_LAT - 1) begin
            mem_cnt = 0;
            mem_bus.MEM_BUSYWAIT = 1'b0;
            if (mem_bus.MEM_READ) begin
               mem_bus.MEM_READDATA = mem_store.exists(mem_bus.MEM_ADDRESS) ?
                                      mem_store[mem_bus.MEM_ADDRESS] : base_block(mem_bus.MEM_ADDRESS);
            end
            if (mem_bus.MEM_WRITE) begin
               wb_addr_seen                     = mem_bus.MEM_ADDRESS;
               wb_data_seen                     = mem_bus.MEM_WRITEDATA;
               mem_store[mem_bus.MEM_ADDRESS]   = mem_bus.MEM_WRITEDATA;
            end
         end else begin
            mem_cnt = mem_cnt + 1;
            mem_bus.MEM_BUSYWAIT = 1'b1;
         end
      end else begin
         mem_cnt = 0;
         mem_bus.MEM_BUSYWAIT = 1'b0;
      end
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [3:0] re, input logic [2:0] we,
                        input logic [31:0] a, input logic [31:0] wd);
      READ_EN    = re;
      WRITE_EN   = we;
      ADDR       = a;
      WRITE_DATA = wd;
      #1;
   endtask

   task automatic wait_ready(output int cycles);
      cycles = 0;
      while (BUSY_WAIT && cycles < BOUND) begin
         next_cycle();
         cycles++;
      end
   endtask

   task automatic wait_mem_read(output int cycles);
      cycles = 0;
      while (!mem_bus.MEM_READ && cycles < BOUND) begin
         next_cycle();
         cycles++;
      end
   endtask

   // One-cycle hit load: issue, then check data and absence of stall.
   task automatic hit_load(input string name, input logic [3:0] re,
                           input logic [31:0] a, input logic [31:0] exp);
      next_cycle();
      drive(re, 3'b000, a, 32'h0);
      check(name, READ_DATA, exp);
      check({name, "_busy"}, BUSY_WAIT, 1'b0);
   endtask

   task automatic hit_store(input string name, input logic [2:0] we,
                            input logic [31:0] a, input logic [31:0] wd);
      next_cycle();
      drive(4'b0000, we, a, wd);
      check({name, "_busy"}, BUSY_WAIT, 1'b0);
      check({name, "_rdata"}, READ_DATA, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      RESET = 1'b1;
      drive(4'b0000, 3'b000, 32'h0, 32'h0);
      repeat (2) next_cycle();
      check("rst_busy", BUSY_WAIT, 1'b0);
      check("rst_mem_read", mem_bus.MEM_READ, 1'b0);
      check("rst_mem_write", mem_bus.MEM_WRITE, 1'b0);
      check("rst_rdata", READ_DATA, 32'h0);
      RESET = 1'b0;

      // Cold miss on LW 0x40: fetch block 0x4, fill, then hit.
      next_cycle();
      drive(LW, 3'b000, 32'h0000_0040, 32'h0);
      check("miss_busy", BUSY_WAIT, 1'b1);
      check("miss_mem_read_early", mem_bus.MEM_READ, 1'b0);
      next_cycle();
      check("fetch_mem_read", mem_bus.MEM_READ, 1'b1);
      check("fetch_mem_write", mem_bus.MEM_WRITE, 1'b0);
      check("fetch_addr", mem_bus.MEM_ADDRESS, 28'h0000004);
      wait_ready(cyc);
      check("miss_cycles", cyc, 6);
      check("lw_40", READ_DATA, 32'h8765_4321);
      check("post_fill_mem_read", mem_bus.MEM_READ, 1'b0);

      // Zero-latency hits, extension and a store hit.
      hit_load("lb_43", LB, 32'h0000_0043, 32'hFFFF_FF87);
      check("lb_no_mem_read", mem_bus.MEM_READ, 1'b0);
      hit_load("lbu_43", LBU, 32'h0000_0043, 32'h0000_0087);
      hit_store("sh_42", SH, 32'h0000_0042, 32'h0000_BEEF);
      hit_load("lw_40_after_sh", LW, 32'h0000_0040, 32'hBEEF_4321);

      // Conflicting tag on index 4: dirty victim written back, then fetch 0x14.
      next_cycle();
      drive(LW, 3'b000, 32'h0000_0140, 32'h0);
      check("conflict_busy", BUSY_WAIT, 1'b1);
      next_cycle();
      check("wb_mem_write", mem_bus.MEM_WRITE, 1'b1);
      check("wb_mem_read", mem_bus.MEM_READ, 1'b0);
      check("wb_addr", mem_bus.MEM_ADDRESS, 28'h0000004);
      check("wb_data", mem_bus.MEM_WRITEDATA, BLK_A_M);
      wait_mem_read(cyc);
      check("refetch_mem_read", mem_bus.MEM_READ, 1'b1);
      check("refetch_addr", mem_bus.MEM_ADDRESS, 28'h0000014);
      check("refetch_mem_write", mem_bus.MEM_WRITE, 1'b0);
      check("wb_seen_addr", wb_addr_seen, 28'h0000004);
      check("wb_seen_data", wb_data_seen, BLK_A_M);
      wait_ready(cyc);
      check("conflict_ready", BUSY_WAIT, 1'b0);
      check("lw_140", READ_DATA, 32'hA5A5_A5A5);
`ifdef DCACHE_STATS_EN
      check("hit_count", HIT_COUNT, 32'd4);
      check("miss_count", MISS_COUNT, 32'd2);
`endif

      // Extension, alignment and precedence corner cases on the new block.
      hit_load("lhu_143", LHU, 32'h0000_0143, 32'h0000_A5A5);
      hit_load("lh_148", LH, 32'h0000_0148, 32'hFFFF_F00D);
      hit_load("lh_149_align", LH, 32'h0000_0149, 32'hFFFF_F00D);
      hit_load("lw_14b_align", LW, 32'h0000_014B, 32'hCAFE_F00D);
      hit_store("sb_14d", SB, 32'h0000_014D, 32'hFFFF_FF5A);
      hit_load("lw_14c_after_sb", LW, 32'h0000_014C, 32'h4444_5A33);
      hit_load("lb_14f", LB, 32'h0000_014F, 32'h0000_0044);
      next_cycle();
      drive(LW, SW, 32'h0000_0144, 32'hDEAD_BEEF);
      check("store_wins_rdata", READ_DATA, 32'h0);
      check("store_wins_busy", BUSY_WAIT, 1'b0);
      hit_load("lw_144_after_sw", LW, 32'h0000_0144, 32'hDEAD_BEEF);
      next_cycle();
      drive(4'b0000, 3'b000, 32'h0000_0144, 32'h0);
      check("idle_rdata", READ_DATA, 32'h0);
      check("idle_busy", BUSY_WAIT, 1'b0);

      // Reset in the middle of a fetch abandons it and clears valid bits.
      next_cycle();
      drive(LW, 3'b000, 32'h0000_0040, 32'h0);
      wait_mem_read(cyc);
      check("pre_reset_fetch", mem_bus.MEM_READ, 1'b1);
      RESET = 1'b1;
      next_cycle();
      check("mid_rst_mem_read", mem_bus.MEM_READ, 1'b0);
      check("mid_rst_mem_write", mem_bus.MEM_WRITE, 1'b0);
      check("mid_rst_busy", BUSY_WAIT, 1'b0);
`ifdef DCACHE_STATS_EN
      check("rst_hit_count", HIT_COUNT, 32'd0);
      check("rst_miss_count", MISS_COUNT, 32'd0);
`endif
      RESET = 1'b0;
      #1;
      check("after_rst_miss", BUSY_WAIT, 1'b1);
      next_cycle();
      check("after_rst_fetch", mem_bus.MEM_READ, 1'b1);
      check("after_rst_no_wb", mem_bus.MEM_WRITE, 1'b0);
      check("after_rst_addr", mem_bus.MEM_ADDRESS, 28'h0000004);
      wait_ready(cyc);
      check("after_rst_ready", BUSY_WAIT, 1'b0);
      check("after_rst_lw_40", READ_DATA, 32'hBEEF_4321);

      next_cycle();
      drive(4'b0000, 3'b000, 32'h0, 32'h0);
      next_cycle();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
